// File: rtl/addr_seq_ctrl.sv
// Effective-address sequencing FSM: latches an instruction, steers the address adder
// selects, then walks MAR/PC loads, the memory handshake, indirect re-fetch and writeback.
module addr_seq_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [15:0] ir,
  input  logic [2:0]  nzp,
  input  logic        mem_ready,
  output logic        addr1_sel,
  output logic [1:0]  addr2_sel,
  output logic        ld_mar,
  output logic        mar_from_mdr,
  output logic        ld_pc,
  output logic        ld_r7,
  output logic        ld_reg,
  output logic        ld_cc,
  output logic        mem_en,
  output logic        mem_we,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // state | meaning
  // IDLE  | waiting for start
  // EA    | adder selects driven, PC/MAR/DR load decided by opcode
  // MEM   | memory access, waiting on mem_ready or timeout
  // IND   | MAR <= MDR before the second indirect access
  // WB    | load writeback (DR and CC)
  // DONE  | completion pulse, err if illegal opcode or timeout

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_EA, S_MEM, S_IND, S_WB, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [15:0]   ir_q, ir_n;
  logic [2:0]    nzp_q, nzp_n;
  logic          ind_q, ind_n;
  logic          bad_q, bad_n;
  logic [CW-1:0] cnt, cnt_n;

  logic       a1_n, mar_n, mfm_n, pc_n, r7_n, reg_n, cc_n, en_n, we_n, busy_n, done_n, err_n;
  logic [1:0] a2_n;

  logic unused_ir_bits;
  assign unused_ir_bits = ^ir_q[8:0];

  always_comb begin
    state_n = state;
    ir_n    = ir_q;
    nzp_n   = nzp_q;
    ind_n   = ind_q;
    bad_n   = bad_q;
    cnt_n   = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          ir_n    = ir;
          nzp_n   = nzp;
          ind_n   = (ir[15:13] == 3'b101);
          bad_n   = 1'b0;
          state_n = S_EA;
        end
      end
      S_EA: begin
        case (ir_q[15:12])
          4'b0000, 4'b0100, 4'b1110:                    state_n = S_DONE;
          4'b0010, 4'b0011, 4'b1010, 4'b1011,
          4'b0110, 4'b0111:                             state_n = S_MEM;
          default: begin
            bad_n   = 1'b1;
            state_n = S_DONE;
          end
        endcase
      end
      S_MEM: begin
        // ready takes priority over the timeout limit in the same cycle
        if (mem_ready) begin
          if (ind_q)           state_n = S_IND;
          else if (!ir_q[12])  state_n = S_WB;
          else                 state_n = S_DONE;
        end else if (cnt == CNT_LAST) begin
          bad_n   = 1'b1;
          state_n = S_DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_IND: begin
        ind_n   = 1'b0;
        state_n = S_MEM;
      end
      S_WB:    state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    a1_n   = 1'b0;
    a2_n   = 2'b00;
    mar_n  = 1'b0;
    mfm_n  = 1'b0;
    pc_n   = 1'b0;
    r7_n   = 1'b0;
    reg_n  = 1'b0;
    cc_n   = 1'b0;
    en_n   = 1'b0;
    we_n   = 1'b0;
    done_n = 1'b0;
    err_n  = 1'b0;
    busy_n = (state_n != S_IDLE);
    case (state_n)
      S_EA: begin
        case (ir_n[15:12])
          4'b0000: begin
            a2_n = 2'b11;
            pc_n = |(nzp_n & ir_n[11:9]);
          end
          4'b0100: begin
            if (ir_n[11]) a2_n = 2'b10;
            else          a1_n = 1'b1;
            pc_n = 1'b1;
            r7_n = 1'b1;
          end
          4'b1110: begin
            a2_n  = 2'b11;
            reg_n = 1'b1;
          end
          4'b0010, 4'b0011, 4'b1010, 4'b1011: begin
            a2_n  = 2'b11;
            mar_n = 1'b1;
          end
          4'b0110, 4'b0111: begin
            a1_n  = 1'b1;
            a2_n  = 2'b01;
            mar_n = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        en_n = 1'b1;
        we_n = ir_n[12] & ~ind_n;
      end
      S_IND:  mfm_n = 1'b1;
      S_WB: begin
        reg_n = 1'b1;
        cc_n  = 1'b1;
      end
      S_DONE: begin
        done_n = 1'b1;
        err_n  = bad_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= S_IDLE;
      ir_q         <= '0;
      nzp_q        <= '0;
      ind_q        <= 1'b0;
      bad_q        <= 1'b0;
      cnt          <= '0;
      addr1_sel    <= 1'b0;
      addr2_sel    <= 2'b00;
      ld_mar       <= 1'b0;
      mar_from_mdr <= 1'b0;
      ld_pc        <= 1'b0;
      ld_r7        <= 1'b0;
      ld_reg       <= 1'b0;
      ld_cc        <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_n;
      ir_q         <= ir_n;
      nzp_q        <= nzp_n;
      ind_q        <= ind_n;
      bad_q        <= bad_n;
      cnt          <= cnt_n;
      addr1_sel    <= a1_n;
      addr2_sel    <= a2_n;
      ld_mar       <= mar_n;
      mar_from_mdr <= mfm_n;
      ld_pc        <= pc_n;
      ld_r7        <= r7_n;
      ld_reg       <= reg_n;
      ld_cc        <= cc_n;
      mem_en       <= en_n;
      mem_we       <= we_n;
      busy         <= busy_n;
      done         <= done_n;
      err          <= err_n;
    end
  end

endmodule

// File: tb/tb_addr_seq_ctrl.sv
// Bench for addr_seq_ctrl: a transaction model expands each instruction into the expected
// per-cycle output vectors and the mem_ready pattern, then compares every cycle.
module tb_addr_seq_ctrl;
  localparam int T = 16;

  logic        Clk = 1'b0;
  logic        Reset, start, mem_ready;
  logic [15:0] ir;
  logic [2:0]  nzp;
  logic        addr1_sel, ld_mar, mar_from_mdr, ld_pc, ld_r7, ld_reg, ld_cc;
  logic        mem_en, mem_we, busy, done, err;
  logic [1:0]  addr2_sel;

  addr_seq_ctrl #(.MEM_TIMEOUT(T)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .ir(ir), .nzp(nzp), .mem_ready(mem_ready),
    .addr1_sel(addr1_sel), .addr2_sel(addr2_sel), .ld_mar(ld_mar),
    .mar_from_mdr(mar_from_mdr), .ld_pc(ld_pc), .ld_r7(ld_r7), .ld_reg(ld_reg),
    .ld_cc(ld_cc), .mem_en(mem_en), .mem_we(mem_we), .busy(busy), .done(done), .err(err)
  );

  always #5 Clk = ~Clk;

  logic [13:0] obs;
  assign obs = {addr1_sel, addr2_sel, ld_mar, mar_from_mdr, ld_pc, ld_r7,
                ld_reg, ld_cc, mem_en, mem_we, busy, done, err};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // busy is implied for every non-idle cycle
  function automatic logic [13:0] mk(logic a1, logic [1:0] a2, logic mar, logic mfm,
                                     logic pc, logic r7, logic rg, logic cc,
                                     logic en, logic we, logic dn, logic er);
    return {a1, a2, mar, mfm, pc, r7, rg, cc, en, we, 1'b1, dn, er};
  endfunction

  logic [13:0] exp_q[$];
  bit          rdy_q[$];

  task automatic push(input logic [13:0] v, input bit r);
    exp_q.push_back(v);
    rdy_q.push_back(r);
  endtask

  // One memory access that sees w not-ready cycles before ready; w >= T never completes.
  task automatic access(input int w, input bit we, output bit timed_out);
    logic [13:0] v;
    v = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, we, 0, 0);
    timed_out = (w >= T);
    if (timed_out) begin
      for (int k = 0; k < T; k++) push(v, 1'b0);
    end else begin
      for (int k = 0; k < w; k++) push(v, 1'b0);
      push(v, 1'b1);
    end
  endtask

  task automatic model(input logic [15:0] i, input logic [2:0] z, input int w1, input int w2);
    logic [3:0] op;
    bit mem_op, indir, store, bad, to;
    op = i[15:12];
    exp_q.delete();
    rdy_q.delete();
    mem_op = 0; indir = 0; store = i[12]; bad = 0; to = 0;
    case (op)
      4'h0: push(mk(0, 2'b11, 0, 0, |(z & i[11:9]), 0, 0, 0, 0, 0, 0, 0), bit'($urandom_range(0, 1)));
      4'h4: push(mk(!i[11], i[11] ? 2'b10 : 2'b00, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0), bit'($urandom_range(0, 1)));
      4'hE: push(mk(0, 2'b11, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), bit'($urandom_range(0, 1)));
      4'h2, 4'h3, 4'hA, 4'hB: begin
        push(mk(0, 2'b11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), bit'($urandom_range(0, 1)));
        mem_op = 1;
        indir  = (op[3] == 1'b1);
      end
      4'h6, 4'h7: begin
        push(mk(1, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), bit'($urandom_range(0, 1)));
        mem_op = 1;
      end
      default: begin
        push(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), bit'($urandom_range(0, 1)));
        bad = 1;
      end
    endcase
    if (mem_op) begin
      access(w1, store && !indir, to);
      if (!to && indir) begin
        push(mk(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), bit'($urandom_range(0, 1)));
        access(w2, store, to);
      end
      if (!to && !store) push(mk(0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), bit'($urandom_range(0, 1)));
    end
    push(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, bad | to), 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clk);
      chk("idle", 16'(obs), 16'h0);
      start     = 1'b0;
      mem_ready = 1'(($urandom_range(0, 1)));
    end
  endtask

  // Entered just before an IDLE cycle; starts the instruction and checks every busy cycle.
  task automatic run(input string tag, input logic [15:0] i, input logic [2:0] z,
                     input int w1, input int w2);
    model(i, z, w1, w2);
    @(negedge Clk);
    chk({tag, "_idle"}, 16'(obs), 16'h0);
    start = 1'b1; ir = i; nzp = z; mem_ready = 1'(($urandom_range(0, 1)));
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge Clk);
      chk($sformatf("%s_c%0d", tag, c + 1), 16'(obs), 16'(exp_q[c]));
      start     = 1'(($urandom_range(0, 1)));
      ir        = 16'($urandom);
      nzp       = 3'($urandom);
      mem_ready = rdy_q[c];
    end
    start = 1'b0;
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6)       return $urandom_range(0, 3);
    else if (r == 6) return T - 1;
    else if (r == 7) return T;
    else if (r == 8) return 0;
    else             return $urandom_range(0, T + 4);
  endfunction

  initial begin
    Reset = 1'b1; start = 1'b0; ir = '0; nzp = '0; mem_ready = 1'b0;
    repeat (2) @(negedge Clk);
    chk("reset", 16'(obs), 16'h0);
    Reset = 1'b0;
    idle(1);

    run("br_taken",   16'h0E05, 3'b010, 0, 0);
    run("br_nottkn",  16'h0805, 3'b010, 0, 0);
    run("ldr_wait3",  16'h6283, 3'b000, 3, 0);
    run("sti",        16'hB001, 3'b000, 0, 0);
    run("ld_timeout", 16'h2001, 3'b000, 100, 0);
    run("illegal",    16'hD000, 3'b000, 0, 0);
    run("ld_lastrdy", 16'h2001, 3'b001, T - 1, 0);
    run("ld_exactto", 16'h2001, 3'b001, T, 0);
    run("ldi",        16'hA00F, 3'b100, 0, 0);
    run("ldi_to2",    16'hA00F, 3'b100, 1, T);
    run("st",         16'h3010, 3'b100, 2, 0);
    run("jsr",        16'h4812, 3'b000, 0, 0);
    run("jsrr",       16'h4080, 3'b000, 0, 0);
    run("lea",        16'hE1FF, 3'b111, 0, 0);
    idle(2);

    // reset during the first MEM cycle of an LDI, with start held high
    @(negedge Clk);
    start = 1'b1; ir = 16'hA001; nzp = 3'b000;
    @(negedge Clk);
    start = 1'b0;
    @(negedge Clk);
    chk("rst_pre_mem", 16'(obs), 16'(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)));
    mem_ready = 1'b1; Reset = 1'b1; start = 1'b1;
    @(negedge Clk);
    chk("rst_mid", 16'(obs), 16'h0);
    Reset = 1'b0; start = 1'b0;
    idle(2);
    run("post_rst", 16'h6283, 3'b000, 0, 0);

    for (int n = 0; n < 150; n++) begin
      run($sformatf("rnd%0d", n), 16'($urandom), 3'($urandom), pick_wait(), pick_wait());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
